// File: rtl/bmu_result_buffer_if.sv
// ---------------------------------------------------------------------------
// bmu_result_buffer_if
// Bundles the execute-side push channel, the writeback-side pop channel and
// the decode forwarding lookup of the bit-manipulation result buffer.
//   in_*     : execute result offered to the buffer (valid/ready)
//   out_*    : oldest buffered result offered to writeback (valid/ready)
//   fwd_*    : two source-register lookups against in-flight results
// Modports:
//   slave  : the buffer itself
//   master : the surrounding pipeline (execute, writeback, decode)
// ---------------------------------------------------------------------------
interface bmu_result_buffer_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rd;
    logic [DATA_W-1:0] in_data;
    logic              in_regWrite;

    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_rd;
    logic [DATA_W-1:0] out_data;
    logic              out_regWrite;

    logic [4:0]        fwd_rs1;
    logic [4:0]        fwd_rs2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;

    modport slave (
        input  in_valid, in_rd, in_data, in_regWrite,
        output in_ready,
        output out_valid, out_rd, out_data, out_regWrite,
        input  out_ready,
        input  fwd_rs1, fwd_rs2,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );

    modport master (
        output in_valid, in_rd, in_data, in_regWrite,
        input  in_ready,
        input  out_valid, out_rd, out_data, out_regWrite,
        output out_ready,
        output fwd_rs1, fwd_rs2,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );
endinterface

// File: rtl/bmu_result_buffer.sv
// ---------------------------------------------------------------------------
// bmu_result_buffer
// Two-entry elastic buffer between the combinational bit-manipulation execute
// unit and register-file writeback. Results are held stable while writeback
// stalls, in-flight results can be forwarded to decode, and upstream stall
// cycles are counted.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   flush     : drop all buffered entries (pipeline redirect)
//   bus       : push/pop/forward channels (bmu_result_buffer_if.slave)
//   stall_cnt : saturating count of cycles with in_valid=1 and in_ready=0
// ---------------------------------------------------------------------------
module bmu_result_buffer #(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    bmu_result_buffer_if.slave     bus,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
        logic              wr;
    } entry_t;

    entry_t [1:0] ent;
    logic         head;
    logic [1:0]   count;

    logic push;
    logic pop;
    logic wr_idx;
    logic yng;      // index of the younger entry when two are held

    // in_ready comes from registered state only, so upstream never sees a
    // combinational path from out_ready.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);

    assign push   = bus.in_valid  && bus.in_ready  && !flush;
    assign pop    = bus.out_valid && bus.out_ready && !flush;
    // count is 0 or 1 whenever a push is legal, so head+count mod 2 is an XOR.
    assign wr_idx = head ^ count[0];
    assign yng    = ~head;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= 1'b0;
            count <= 2'd0;
            ent   <= '0;
        end else if (flush) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                ent[wr_idx].rd   <= bus.in_rd;
                ent[wr_idx].data <= bus.in_data;
                // x0 is hardwired zero: never carry it as a real write.
                ent[wr_idx].wr   <= bus.in_regWrite && (bus.in_rd != 5'd0);
            end
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        bus.out_rd       = '0;
        bus.out_data     = '0;
        bus.out_regWrite = 1'b0;
        if (count != 2'd0) begin
            bus.out_rd       = ent[head].rd;
            bus.out_data     = ent[head].data;
            bus.out_regWrite = ent[head].wr;
        end
    end

    // Forwarding: one lookup per decode source port. Older entry is at head,
    // younger at head+1 and only valid when two entries are held; the younger
    // match takes precedence because it is the later write to that register.
    logic [1:0][4:0]        fwd_rs;
    logic [1:0]             fwd_hit;
    logic [1:0][DATA_W-1:0] fwd_data;

    assign fwd_rs[0]     = bus.fwd_rs1;
    assign fwd_rs[1]     = bus.fwd_rs2;
    assign bus.fwd_hit1  = fwd_hit[0];
    assign bus.fwd_hit2  = fwd_hit[1];
    assign bus.fwd_data1 = fwd_data[0];
    assign bus.fwd_data2 = fwd_data[1];

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic hit_old;
        logic hit_yng;

        assign hit_old = (count != 2'd0) && ent[head].wr &&
                         (ent[head].rd == fwd_rs[p]) && (fwd_rs[p] != 5'd0);
        assign hit_yng = (count == 2'd2) && ent[yng].wr &&
                         (ent[yng].rd == fwd_rs[p]) && (fwd_rs[p] != 5'd0);

        always_comb begin
            fwd_hit[p]  = hit_old || hit_yng;
            fwd_data[p] = '0;
            if (hit_yng)
                fwd_data[p] = ent[yng].data;
            else if (hit_old)
                fwd_data[p] = ent[head].data;
        end
    end

    // Stall counter survives flush so perf sampling spans redirects.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (bus.in_valid && !bus.in_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: doc/bmu_result_buffer.md
# bmu_result_buffer

Two-entry elastic result buffer between the combinational bit-manipulation execute unit and register-file writeback. It captures each execute result (destination register, data, write enable) under a valid/ready handshake and holds it stable while writeback stalls. It also exposes operand-forwarding lookups against in-flight results, and counts upstream stall cycles for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, result data width
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  drop all buffered entries (pipeline redirect)
- in_valid  in  1  execute result present this cycle
- in_ready  out  1  buffer can accept a result this cycle
- in_rd  in  5  destination register index
- in_data  in  DATA_W  result value from execute unit
- in_regWrite  in  1  result must be written to register file
- out_valid  out  1  oldest entry presented to writeback
- out_ready  in  1  writeback consumes the presented entry
- out_rd  out  5  oldest entry destination
- out_data  out  DATA_W  oldest entry data
- out_regWrite  out  1  oldest entry write enable
- fwd_rs1, fwd_rs2  in  5 each  source indices queried by decode
- fwd_hit1, fwd_hit2  out  1 each  matching in-flight result exists
- fwd_data1, fwd_data2  out  DATA_W each  forwarded value
- stall_cnt  out  STALL_CNT_W  cycles with in_valid=1 and in_ready=0

## Operation
- Storage: 2 entries {rd, data, regWrite}, read pointer head (1 bit), occupancy count (0..2).
- in_ready = (count != 2); depends only on registered state, never on out_ready.
- Push when in_valid && in_ready && !flush: write entry at (head + count) mod 2.
- Capture rule: stored regWrite = in_regWrite && (in_rd != 0); x0 writes are never buffered as writes.
- Pop when out_valid && out_ready && !flush: head toggles, count decrements.
- Push and pop in the same cycle: count unchanged; legal at count 1 and count 2 is impossible (in_ready=0). At count 0 only a push occurs; no same-cycle bypass.
- out_valid = (count != 0); out_rd/out_data/out_regWrite = entry[head]. These outputs are zero when count = 0.
- Flush: next cycle count=0, head=0; push and pop in that cycle are suppressed. flush has priority over everything except rst.
- Forwarding (combinational, per port): hit when some valid entry has regWrite=1 and rd == fwd_rsN and fwd_rsN != 0. If both entries match, the younger one (head+1) wins. fwd_dataN = 0 on miss.
- stall_cnt increments when in_valid && !in_ready, saturates at all-ones, cleared only by rst (not by flush).

## Timing
- Reset: count=0, head=0, stall_cnt=0. Next cycle: out_valid=0, in_ready=1, out_* = 0, fwd_hit*=0.
- Latency: a result accepted at edge N is visible on out_* after edge N (cycle N+1), at the earliest.
- Throughput: 1 result/cycle sustained when out_ready held high.
- Stability: while out_valid=1 and out_ready=0, out_* hold constant.
- Backpressure: second result accepted with count=1 and out_ready=0; a third sees in_ready=0 until a pop.
- rst asserted mid-operation discards entries in the same edge, identical to power-on reset.

## Test plan
- Reset, then push {rd=5, data=0xA5A5A5A5, regWrite=1} with out_ready=1 -> out_valid next cycle with the same fields; popped; out_valid=0 the following cycle.
- out_ready=0, push rd=1/0x11 then rd=2/0x22, keep in_valid=1 for 3 more cycles -> in_ready=0 after second push, stall_cnt=3; out_ready=1 -> 0x11 then 0x22 in order.
- Push rd=0, data=0xFFFFFFFF, regWrite=1 -> out_regWrite=0; fwd_rs1=0 -> fwd_hit1=0.
- Buffer holds rd=7/0x1 (older) and rd=7/0x2 (younger), fwd_rs1=7, fwd_rs2=3 -> fwd_hit1=1, fwd_data1=0x2, fwd_hit2=0, fwd_data2=0.
- Count=2, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, no entry written.
- Hold in_valid=1 and in_ready=0 for 65540 cycles (STALL_CNT_W=16) -> stall_cnt=0xFFFF; pulse rst -> stall_cnt=0.
